// File: rtl/cfg_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg : shared definitions for the configuration register file.
//   state_t          - command parser states
//   OP_WRITE/OP_READ - value of the op bit in a header byte
//   OP_BIT/ADDR_MSB  - header byte field positions
//   nbytes()         - number of bytes needed to carry a DATA_W-bit register
// -----------------------------------------------------------------------------
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WDATA  = 2'd1,
      COMMIT = 2'd2,
      RDATA  = 2'd3
   } state_t;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   localparam int OP_BIT   = 7;
   localparam int ADDR_MSB = 6;

   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/cfg_regfile_if.sv
// -----------------------------------------------------------------------------
// cfg_regfile_if : byte streams between the UART and the register file.
//   rx_data/rx_valid/rx_ready : command bytes from the UART receiver
//   tx_data/tx_valid/tx_ready : read-back bytes to the UART transmitter
// slave modport is the register file, master modport is the UART side.
// -----------------------------------------------------------------------------
interface cfg_regfile_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

endinterface

// File: rtl/cfg_regfile.sv
// -----------------------------------------------------------------------------
// cfg_regfile : command-driven configuration register file.
// Parses a byte stream of write/read commands (header byte: bit7 op,
// bits6:0 address; writes followed by the register value MSB first) into
// NUM_REGS registers of DATA_W bits and returns read data as bytes.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - rx (command) and tx (read-back) byte handshakes
//   stall       - bit i holds off a pending commit to register i
//   regs        - packed register contents, register i at [i*DATA_W +: DATA_W]
//   reg_update  - one-cycle pulse on bit i when register i is written
//   cmd_err     - one-cycle pulse when a command names a nonexistent register
// -----------------------------------------------------------------------------
module cfg_regfile
   import cfg_pkg::*;
#(
   parameter int                          NUM_REGS   = 4,
   parameter int                          DATA_W     = 8,
   parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   cfg_regfile_if.slave                 bus,
   input  logic [NUM_REGS-1:0]          stall,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic [NUM_REGS-1:0]          reg_update,
   output logic                         cmd_err
);

   localparam int         NB     = nbytes(DATA_W);
   localparam int         SNAP_W = NB * 8;
   localparam int         STG_W  = DATA_W + 8;
   localparam logic [2:0] LAST   = 3'(NB - 1);
   localparam logic [7:0] NREG8  = 8'(NUM_REGS);

   if (NUM_REGS < 1 || NUM_REGS > 128) begin : g_bad_num_regs
      $error("cfg_regfile: NUM_REGS must be in 1..128");
   end
   if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("cfg_regfile: DATA_W must be in 1..32");
   end

   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [ADDR_MSB:0]      addr_q, addr_d;
   logic [STG_W-1:0]       stage_q, stage_d;
   logic [SNAP_W-1:0]      snap_q, snap_d;
   logic [DATA_W-1:0]      regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]    upd_q, upd_d;
   logic                   err_q, err_d;
   logic                   wr_en;
   logic                   stall_sel;
   logic                   rx_acc, tx_acc;
   logic [ADDR_MSB:0]      hdr_addr;
   logic                   hdr_bad, addr_bad;
   logic                   stage_unused;

   assign rx_acc   = bus.rx_valid && bus.rx_ready;
   assign tx_acc   = bus.tx_valid && bus.tx_ready;
   assign hdr_addr = bus.rx_data[ADDR_MSB:0];
   assign hdr_bad  = {1'b0, hdr_addr} >= NREG8;
   assign addr_bad = {1'b0, addr_q} >= NREG8;

   // The top byte of the staging register only ever holds bits that have
   // already shifted past the register width (first byte's spare bits).
   assign stage_unused = ^stage_q[STG_W-1:DATA_W];

   assign bus.rx_ready = (state_q == IDLE) || (state_q == WDATA);
   assign bus.tx_valid = (state_q == RDATA);
   assign bus.tx_data  = bus.tx_valid ? snap_q[SNAP_W-1 -: 8] : 8'h00;

   assign reg_update = upd_q;
   assign cmd_err    = err_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   // Stall bit of the register being committed.
   always_comb begin
      stall_sel = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == (ADDR_MSB+1)'(i)) stall_sel = stall[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      stage_d = stage_q;
      snap_d  = snap_q;
      upd_d   = '0;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_acc) begin
               cnt_d = '0;
               if (bus.rx_data[OP_BIT] == OP_WRITE) begin
                  addr_d  = hdr_addr;
                  state_d = WDATA;
               end else begin
                  // Snapshot zero-extended to whole bytes; a bad address
                  // matches no register and leaves it all zero.
                  snap_d = '0;
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (hdr_addr == (ADDR_MSB+1)'(i)) snap_d[DATA_W-1:0] = regs_q[i];
                  end
                  err_d   = hdr_bad;
                  state_d = RDATA;
               end
            end
         end

         WDATA: begin
            if (rx_acc) begin
               stage_d = {stage_q[DATA_W-1:0], bus.rx_data};
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = COMMIT;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         COMMIT: begin
            if (addr_bad) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (!stall_sel) begin
               wr_en   = 1'b1;
               for (int i = 0; i < NUM_REGS; i++) begin
                  upd_d[i] = (addr_q == (ADDR_MSB+1)'(i));
               end
               state_d = IDLE;
            end
         end

         RDATA: begin
            if (tx_acc) begin
               snap_d = snap_q << 8;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         stage_q <= '0;
         snap_q  <= '0;
         upd_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         stage_q <= stage_d;
         snap_q  <= snap_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
         if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr_q == (ADDR_MSB+1)'(i)) regs_q[i] <= stage_q[DATA_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_cfg_regfile.sv
// -----------------------------------------------------------------------------
// tb_cfg_regfile : directed bench for cfg_regfile (NUM_REGS=4, DATA_W=12).
// Stimulus pushes expected tx bytes, register updates and error pulses into
// queues; a negedge monitor pops and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_cfg_regfile;

   localparam int                 NREGS = 4;
   localparam int                 DW    = 12;
   localparam logic [NREGS*DW-1:0] RV   = 48'h0A5_001_00F_000;

   typedef struct {
      logic [NREGS-1:0] vec;
      int               idx;
      logic [DW-1:0]    val;
   } upd_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREGS-1:0]      stall;
   logic [NREGS*DW-1:0]   regs;
   logic [NREGS-1:0]      reg_update;
   logic                  cmd_err;

   cfg_regfile_if bus ();

   cfg_regfile #(
      .NUM_REGS   (NREGS),
      .DATA_W     (DW),
      .RESET_VALS (RV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .stall      (stall),
      .regs       (regs),
      .reg_update (reg_update),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] exp_tx [$];
   upd_t       exp_upd [$];
   int         exp_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rg(input int i);
      return regs[i*DW +: DW];
   endfunction

   // Monitor: compares every DUT output event against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tx_valid) begin
            if (exp_tx.size() == 0) begin
               chk("tx_unexpected", {56'd0, bus.tx_data}, 64'hFFFF);
            end else if (bus.tx_ready) begin
               chk("tx_byte", {56'd0, bus.tx_data}, {56'd0, exp_tx.pop_front()});
            end else begin
               chk("tx_hold", {56'd0, bus.tx_data}, {56'd0, exp_tx[0]});
            end
         end
         if (reg_update != '0) begin
            if (exp_upd.size() == 0) begin
               chk("upd_unexpected", {60'd0, reg_update}, 64'd0);
            end else begin
               upd_t u;
               u = exp_upd.pop_front();
               chk("reg_update", {60'd0, reg_update}, {60'd0, u.vec});
               chk("upd_value", {52'd0, rg(u.idx)}, {52'd0, u.val});
            end
         end
         if (cmd_err) begin
            if (exp_err == 0) begin
               chk("err_unexpected", 64'd1, 64'd0);
            end else begin
               exp_err--;
               chk("cmd_err", {63'd0, cmd_err}, 64'd1);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rx_ready) chk("rx_accept_wait", {63'd0, bus.rx_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_tx_done();
      int n;
      n = 0;
      while (exp_tx.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_tx.size() != 0) chk("tx_drain_wait", 64'(exp_tx.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      stall        = '0;
      do_reset();

      // Reset state and read-back of reset value
      chk("rst_regs", {16'd0, regs}, {16'd0, RV});
      chk("rst_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
      chk("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
      chk("rst_upd", {60'd0, reg_update}, 64'd0);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h0F);
      send_byte(8'h81);
      wait_tx_done();

      // Write reg2 = 0x34C (upper nibble of 0xF3 dropped)
      exp_upd.push_back('{vec: 4'b0100, idx: 2, val: 12'h34C});
      send_byte(8'h02);
      send_byte(8'hF3);
      send_byte(8'h4C);
      chk("wr_commit_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
      chk("wr_reg2_before", {52'd0, rg(2)}, 64'h001);
      @(posedge clk); #1;
      chk("wr_reg2_after", {52'd0, rg(2)}, 64'h34C);
      chk("wr_rx_ready_back", {63'd0, bus.rx_ready}, 64'd1);

      // Stalled write to reg0
      stall[0] = 1'b1;
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h23);
      for (int i = 0; i < 10; i++) begin
         chk("stall_reg0", {52'd0, rg(0)}, 64'h000);
         chk("stall_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
         @(posedge clk); #1;
      end
      exp_upd.push_back('{vec: 4'b0001, idx: 0, val: 12'h123});
      stall[0] = 1'b0;
      @(posedge clk); #1;
      chk("unstall_reg0", {52'd0, rg(0)}, 64'h123);
      chk("unstall_rx_ready", {63'd0, bus.rx_ready}, 64'd1);

      // Bad-address write
      exp_err++;
      send_byte(8'h05);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("badwr_rx_ready_low", {63'd0, bus.rx_ready}, 64'd0);
      @(posedge clk); #1;
      chk("badwr_cmd_err", {63'd0, cmd_err}, 64'd1);
      chk("badwr_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
      chk("badwr_regs", {16'd0, regs}, {16'd0, 48'h0A5_34C_00F_123});
      @(posedge clk); #1;
      chk("badwr_err_single", {63'd0, cmd_err}, 64'd0);

      // Bad-address read
      exp_err++;
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
      send_byte(8'h85);
      wait_tx_done();

      // Backpressured read of reg3, then an immediate read of reg2
      bus.tx_ready = 1'b0;
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'hA5);
      send_byte(8'h83);
      repeat (3) @(posedge clk);
      #1;
      bus.tx_ready = 1'b1;
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'h4C);
      send_byte(8'h82);
      wait_tx_done();

      // Reset in the middle of a write to reg3
      send_byte(8'h03);
      send_byte(8'h77);
      do_reset();
      chk("midrst_regs", {16'd0, regs}, {16'd0, RV});
      chk("midrst_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
      chk("midrst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
      exp_upd.push_back('{vec: 4'b0010, idx: 1, val: 12'hBCD});
      send_byte(8'h01);
      send_byte(8'hAB);
      send_byte(8'hCD);
      @(posedge clk); #1;
      chk("midrst_reg3", {52'd0, rg(3)}, 64'h0A5);
      exp_tx.push_back(8'h0B);
      exp_tx.push_back(8'hCD);
      send_byte(8'h81);
      wait_tx_done();

      repeat (2) @(posedge clk);
      #1;
      chk("end_tx_queue", 64'(exp_tx.size()), 64'd0);
      chk("end_upd_queue", 64'(exp_upd.size()), 64'd0);
      chk("end_err_pending", 64'(exp_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
